// File: rtl/button_pkg.sv
// button_pkg: shared types and constants for the push-button reader.
// The optional auto-repeat feature is enabled by defining BUTTON_REPEAT_EN.
package button_pkg;

    // Default timing for a 50 MHz CLOCK_50.
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 1_000_000;   // 20 ms
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 50_000_000;  // 1 s
    localparam int unsigned DEF_REPEAT_CYCLES     = 10_000_000;  // 200 ms

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_t;

    // Counter width for a counter that must hold values up to cycles-1,
    // with one spare bit of headroom.
    function automatic int cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/button_reader_if.sv
// button_reader_if: raw pad input plus the clean event outputs of the reader.
// slave  = the reader itself, master = the pad / consumer side.
interface button_reader_if;

    logic BUTTON_IN;
    logic pressed;
    logic press_pulse;
    logic release_pulse;
    logic short_press;
    logic long_press;

    modport master (
        output BUTTON_IN,
        input  pressed,
        input  press_pulse,
        input  release_pulse,
        input  short_press,
        input  long_press
    );

    modport slave (
        input  BUTTON_IN,
        output pressed,
        output press_pulse,
        output release_pulse,
        output short_press,
        output long_press
    );

endinterface

// File: rtl/button_sync.sv
// button_sync: two-flop synchronizer for the raw button pad, followed by
// polarity normalization so btn_act is 1 while the button is pressed.
// Reset loads the released pad level so no phantom press appears after reset.
module button_sync #(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic BUTTON_IN,
    output logic btn_act
);

    localparam logic RELEASED_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;

    logic sync_1;
    logic sync_2;

    // two-stage metastability filter on the asynchronous pad
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync_1 <= RELEASED_LEVEL;
            sync_2 <= RELEASED_LEVEL;
        end else begin
            sync_1 <= BUTTON_IN;
            sync_2 <= sync_1;
        end
    end

    assign btn_act = ACTIVE_LOW ? ~sync_2 : sync_2;

endmodule

// File: rtl/button_reader.sv
// button_reader: synchronizes and debounces one push-button and emits
// single-cycle press / release / short / long event pulses.
// Define BUTTON_REPEAT_EN to re-fire press_pulse every REPEAT_CYCLES while
// the button stays in the long-hold state.
//
// state       | meaning
// ------------+------------------------------------------------------------
// IDLE        | released level accepted, waiting for btn_act
// DEB_PRESS   | btn_act seen, counting stable pressed cycles
// HELD        | press accepted, hold_cnt running towards long_press
// LONG_HELD   | long_press already issued for this press
// DEB_RELEASE | btn_act dropped, counting stable released cycles; a bounce
//             | returns to the origin state (HELD or LONG_HELD)
module button_reader
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter bit          ACTIVE_LOW        = 1'b1
`ifdef BUTTON_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES     = DEF_REPEAT_CYCLES
`endif
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    button_reader_if.slave bus
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

`ifdef BUTTON_REPEAT_EN
    localparam int REP_W = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`endif

    logic btn_act;

    btn_state_t        state_q, state_d;
    logic              origin_long_q, origin_long_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d, deb_inc;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`ifdef BUTTON_REPEAT_EN
    logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
`endif

    logic pressed_q, pressed_d;
    logic press_pulse_q, press_pulse_d;
    logic release_pulse_q, release_pulse_d;
    logic short_press_q, short_press_d;
    logic long_press_q, long_press_d;

    button_sync #(
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_sync (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .BUTTON_IN (bus.BUTTON_IN),
        .btn_act   (btn_act)
    );

    // The debounce compare looks at the incremented count so the IDLE cycle
    // that first saw btn_act counts towards the DEBOUNCE_CYCLES stable cycles.
    assign deb_inc = deb_cnt_q + DEB_W'(1);

    // next-state, counter and event decode
    always_comb begin
        state_d         = state_q;
        origin_long_d   = origin_long_q;
        deb_cnt_d       = deb_cnt_q;
        hold_cnt_d      = hold_cnt_q;
`ifdef BUTTON_REPEAT_EN
        rep_cnt_d       = rep_cnt_q;
`endif
        pressed_d       = pressed_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        short_press_d   = 1'b0;
        long_press_d    = 1'b0;

        case (state_q)
            IDLE: begin
                pressed_d  = 1'b0;
                deb_cnt_d  = '0;
                hold_cnt_d = '0;
`ifdef BUTTON_REPEAT_EN
                rep_cnt_d  = '0;
`endif
                if (btn_act) begin
                    state_d = DEB_PRESS;
                end
            end

            DEB_PRESS: begin
                if (!btn_act) begin
                    state_d = IDLE;
                end else begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_LAST) begin
                        state_d       = HELD;
                        pressed_d     = 1'b1;
                        press_pulse_d = 1'b1;
                        hold_cnt_d    = '0;
                    end
                end
            end

            HELD: begin
                // Terminal count wins over a simultaneous drop of btn_act:
                // long_press fires and the release debounce remembers it.
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d      = LONG_HELD;
                    long_press_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
                if (!btn_act) begin
                    state_d       = DEB_RELEASE;
                    deb_cnt_d     = '0;
                    origin_long_d = (hold_cnt_q == HOLD_LAST);
                end
            end

            LONG_HELD: begin
`ifdef BUTTON_REPEAT_EN
                if (rep_cnt_q == REP_LAST) begin
                    press_pulse_d = 1'b1;
                    rep_cnt_d     = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
                if (!btn_act) begin
                    state_d       = DEB_RELEASE;
                    deb_cnt_d     = '0;
                    origin_long_d = 1'b1;
                end
            end

            DEB_RELEASE: begin
                if (btn_act) begin
                    state_d = origin_long_q ? LONG_HELD : HELD;
                end else begin
                    deb_cnt_d = deb_inc;
                    if (deb_inc == DEB_LAST) begin
                        state_d         = IDLE;
                        pressed_d       = 1'b0;
                        release_pulse_d = 1'b1;
                        short_press_d   = ~origin_long_q;
                        deb_cnt_d       = '0;
                        hold_cnt_d      = '0;
`ifdef BUTTON_REPEAT_EN
                        rep_cnt_d       = '0;
`endif
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                pressed_d = 1'b0;
            end
        endcase
    end

    // state, counters and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            origin_long_q   <= 1'b0;
            deb_cnt_q       <= '0;
            hold_cnt_q      <= '0;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_q       <= '0;
`endif
            pressed_q       <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            short_press_q   <= 1'b0;
            long_press_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            origin_long_q   <= origin_long_d;
            deb_cnt_q       <= deb_cnt_d;
            hold_cnt_q      <= hold_cnt_d;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_q       <= rep_cnt_d;
`endif
            pressed_q       <= pressed_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            short_press_q   <= short_press_d;
            long_press_q    <= long_press_d;
        end
    end

    assign bus.pressed       = pressed_q;
    assign bus.press_pulse   = press_pulse_q;
    assign bus.release_pulse = release_pulse_q;
    assign bus.short_press   = short_press_q;
    assign bus.long_press    = long_press_q;

endmodule
